// File: rtl/n2r_slice_fifo.sv
// n2r_slice_fifo
//   Elastic buffer behind n2r_buffer. It captures every slice word strobed by
//   in_valid. The upstream side has no backpressure, so a slice that arrives
//   while the buffer is full and not draining is dropped, and the sticky
//   overflow flag is set. Queued slices go to the multi-MAC cores over a
//   first-word-fall-through valid/ready interface. The buffer also tracks each
//   slice's position within the ROWxCOL matrix and flags the last slice.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low
//   in_valid   slice strobe (n2r_buffer slice_done)
//   in_data    slice word, OUT_WIDTH bits
//   out_ready  cores accept out_data this cycle
//   out_valid  out_data holds a queued slice
//   out_data   head slice; core c lane is
//              out_data[OUT_WIDTH-1-c*CHUNK_SIZE*WIDTH -: CHUNK_SIZE*WIDTH]
//   out_last   head slice is the final slice of its matrix
//   count      entries held
//   full       count == DEPTH
//   empty      count == 0
//   overflow   sticky, a slice was dropped since reset
module n2r_slice_fifo #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned CHUNK_SIZE = 2,
  parameter int unsigned NUM_CORES  = 2,
  parameter int unsigned ROW        = 8,
  parameter int unsigned COL        = 6,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned OUT_WIDTH = WIDTH * CHUNK_SIZE * NUM_CORES,
  localparam int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [OUT_WIDTH-1:0] in_data,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned SLICES = ROW * COL / (CHUNK_SIZE * NUM_CORES);
  localparam int unsigned IW     = (SLICES > 1) ? $clog2(SLICES) : 1;

  localparam logic [IW-1:0]    LastIdx  = IW'(SLICES - 1);
  localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);

  if ((ROW * COL) % (CHUNK_SIZE * NUM_CORES) != 0) begin : g_bad_slices
    $error("ROW*COL must be a multiple of CHUNK_SIZE*NUM_CORES");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and at least 2");
  end

  logic [OUT_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             overflow_q, overflow_d;

  logic push;
  logic pop;

  // Status and handshake
  assign empty     = (count_q == '0);
  assign full      = (count_q == DepthCnt);
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  // A pop in the same cycle frees a slot, so a full buffer can still accept.
  assign push      = in_valid & (~full | pop);

  // Next state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    idx_d      = idx_q;
    overflow_d = overflow_q;

    // Pointers wrap naturally because DEPTH is a power of 2.
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      idx_d    = (idx_q == LastIdx) ? '0 : idx_q + IW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (in_valid && !push) begin
      overflow_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; out_valid gates its meaning.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  // Outputs
  assign out_data = mem[rd_ptr_q];
  assign out_last = out_valid & (idx_q == LastIdx);
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_n2r_slice_fifo.sv
module tb_n2r_slice_fifo;

  localparam int DEPTH  = 4;
  localparam int SLICES = 12;
  localparam logic [63:0] BASE = 64'h0100_0200_0700_0800;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] in_data;
  logic        out_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_last;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  // Model state, owned by the monitor
  logic [63:0] sb_q[$];
  int          m_count = 0;
  int          m_idx   = 0;
  bit          m_ovf   = 1'b0;
  int          pop_cnt = 0;
  int          last_cnt = 0;
  bit          chk_en  = 1'b0;

  n2r_slice_fifo #(
    .WIDTH      (16),
    .CHUNK_SIZE (2),
    .NUM_CORES  (2),
    .ROW        (8),
    .COL        (6),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Monitor/scoreboard: at the negedge, inputs and outputs are stable, and the
  // model predicts what the coming posedge does.
  always @(negedge clk) begin
    logic        m_pop;
    logic        m_push;
    logic [63:0] exp;
    if (!rst_n) begin
      sb_q.delete();
      m_count = 0;
      m_idx   = 0;
      m_ovf   = 1'b0;
    end else if (chk_en) begin
      check("out_valid", 64'(out_valid), 64'(m_count != 0));
      check("count", 64'(count), 64'(m_count));
      check("full", 64'(full), 64'(m_count == DEPTH));
      check("empty", 64'(empty), 64'(m_count == 0));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("out_last", 64'(out_last), 64'((m_count != 0) && (m_idx == SLICES - 1)));
      m_pop  = (m_count != 0) && out_ready;
      m_push = in_valid && ((m_count < DEPTH) || m_pop);
      if (m_pop) begin
        exp = sb_q.pop_front();
        check("out_data", out_data, exp);
        pop_cnt++;
        if (out_last) last_cnt++;
        m_idx = (m_idx == SLICES - 1) ? 0 : m_idx + 1;
      end
      if (m_push) sb_q.push_back(in_data);
      else if (in_valid) m_ovf = 1'b1;
      m_count = m_count + int'(m_push) - int'(m_pop);
    end
  end

  task automatic step(input logic v, input logic [63:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) step(1'b1, 64'hdead, 1'b1);
    rst_n = 1'b1;
  endtask

  initial begin
    int p0;
    int l0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;

    // 1: reset with in_valid held high
    do_reset(2);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_ovf", 64'(overflow), 64'd0);
    chk_en = 1'b1;

    // 2: stream one matrix with the cores always ready
    p0 = pop_cnt; l0 = last_cnt;
    for (int k = 0; k < SLICES; k++) step(1'b1, BASE + 64'(k), 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1);
    check("t2_pops", 64'(pop_cnt - p0), 64'd12);
    check("t2_lasts", 64'(last_cnt - l0), 64'd1);
    check("t2_empty", 64'(empty), 64'd1);

    // 3: fill with cores stalled; the fifth slice is dropped
    for (int k = 0; k < 5; k++) step(1'b1, 64'hA0 + 64'(k), 1'b0);
    check("t3_count", 64'(count), 64'd4);
    check("t3_full", 64'(full), 64'd1);
    check("t3_ovf", 64'(overflow), 64'd1);
    for (int k = 0; k < 5; k++) step(1'b0, '0, 1'b1);
    check("t3_empty", 64'(empty), 64'd1);

    // 4: full, push and pop together
    do_reset(2);
    for (int k = 0; k < 4; k++) step(1'b1, 64'hB0 + 64'(k), 1'b0);
    step(1'b1, 64'hBEEF, 1'b1);
    check("t4_count", 64'(count), 64'd4);
    check("t4_ovf", 64'(overflow), 64'd0);
    for (int k = 0; k < 5; k++) step(1'b0, '0, 1'b1);

    // 5: 24 slices with the cores ready every other cycle
    do_reset(2);
    p0 = pop_cnt; l0 = last_cnt;
    for (int i = 0; i < 48; i++) step(1'b0 + (i % 2 == 0), 64'hC00 + 64'(i), 1'b0 + (i % 2 == 1));
    for (int k = 0; k < 6; k++) step(1'b0, '0, 1'(k % 2));
    check("t5_pops", 64'(pop_cnt - p0), 64'd24);
    check("t5_lasts", 64'(last_cnt - l0), 64'd2);
    check("t5_ovf", 64'(overflow), 64'd0);

    // 6: reset while slices are queued, then one full matrix
    for (int k = 0; k < 3; k++) step(1'b1, 64'hD0 + 64'(k), 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b1, 64'hE0 + 64'(k), 1'b0);
    do_reset(1);
    check("t6_empty", 64'(empty), 64'd1);
    check("t6_count", 64'(count), 64'd0);
    p0 = pop_cnt; l0 = last_cnt;
    for (int k = 0; k < SLICES; k++) step(1'b1, BASE + 64'(k * 3), 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1);
    check("t6_pops", 64'(pop_cnt - p0), 64'd12);
    check("t6_lasts", 64'(last_cnt - l0), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
